// File: rtl/sigrnd_pipe.sv
// sigrnd_pipe: two-stage pipelined significand rounder.
// Stage 1 captures the beat and resolves the round-up decision (inc/inx).
// Stage 2 applies the increment, post-normalizes on carry and produces the
// e3/f3/OVF/INX form consumed by the exponent-rounding/packing stage.
// Valid/ready on both sides; each stage holds while its successor stalls.
module sigrnd_pipe #(
    parameter int EXP_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    // upstream handshake and beat
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic [EXP_W-1:0] e2,
    input  logic [55:0]      f2,
    input  logic [1:0]       RM,
    input  logic             db,
    // downstream handshake and beat
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s_out,
    output logic [10:0]      e3,
    output logic [52:0]      f3,
    output logic [1:0]       RM_out,
    output logic             db_out,
    output logic             OVF,
    output logic             INX
);

    // Rounding mode encodings
    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // Overflow thresholds on the post-rounding biased exponent
    localparam logic [EXP_W-1:0] OVF_DB = EXP_W'(2047);
    localparam logic [EXP_W-1:0] OVF_SG = EXP_W'(255);

    // Bit position of the single-precision lsb inside the 53-bit significand
    localparam int SG_LSB = 29;

    // ------------------------------------------------------------------
    // Pipeline valid bits: [1] = stage 1 occupied, [2] = stage 2 occupied
    // ------------------------------------------------------------------
    logic [2:1] vld_pipe_q, vld_pipe_d;

    // Handshake strobes
    logic s2_adv;   // stage 2 can take a beat this cycle (empty or draining)
    logic s1_adv;   // stage 1 hands its beat to stage 2 this cycle
    logic in_fire;  // input beat accepted this cycle

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic             s1_s_q,   s1_s_d;
    logic [EXP_W-1:0] s1_e_q,   s1_e_d;
    logic [52:0]      s1_sig_q, s1_sig_d;
    logic             s1_inc_q, s1_inc_d;
    logic             s1_inx_q, s1_inx_d;
    logic [1:0]       s1_rm_q,  s1_rm_d;
    logic             s1_db_q,  s1_db_d;

    // ------------------------------------------------------------------
    // Stage 2 (output) registers
    // ------------------------------------------------------------------
    logic             s_out_q,  s_out_d;
    logic [10:0]      e3_q,     e3_d;
    logic [52:0]      f3_q,     f3_d;
    logic [1:0]       rm_out_q, rm_out_d;
    logic             db_out_q, db_out_d;
    logic             ovf_q,    ovf_d;
    logic             inx_q,    inx_d;

    // Stage 1 combinational: round-bit extraction and decision
    logic        in_lsb, in_g, in_r, in_st;
    logic        in_grs;
    logic        in_inc;
    logic [52:0] in_sig;

    // Stage 2 combinational: increment and post-normalization
    logic [53:0]      sum;
    logic [52:0]      sig_r;
    logic [EXP_W-1:0] exp_r;
    logic             ovf_r;

    // Handshake: a stage advances when its successor is empty or advancing
    always_comb begin
        s2_adv   = ~vld_pipe_q[2] | out_ready;
        s1_adv   = vld_pipe_q[1] & s2_adv;
        in_ready = ~vld_pipe_q[1] | s2_adv;
        in_fire  = in_valid & in_ready;

        vld_pipe_d = vld_pipe_q;
        // Stage 1 fills on accept, empties when its beat moves on
        if (in_fire)
            vld_pipe_d[1] = 1'b1;
        else if (s1_adv)
            vld_pipe_d[1] = 1'b0;
        // Stage 2 fills from stage 1, empties when the consumer takes it
        if (s1_adv)
            vld_pipe_d[2] = 1'b1;
        else if (out_ready)
            vld_pipe_d[2] = 1'b0;
    end

    // Stage 1 decode: pick lsb/G/R/S per format and decide the round-up
    always_comb begin
        in_lsb = 1'b0;
        in_g   = 1'b0;
        in_r   = 1'b0;
        in_st  = 1'b0;
        in_sig = '0;
        if (db) begin
            in_lsb = f2[3];
            in_g   = f2[2];
            in_r   = f2[1];
            in_st  = f2[0];
            in_sig = f2[55:3];
        end else begin
            // Everything below the round bit folds into sticky for single
            in_lsb = f2[32];
            in_g   = f2[31];
            in_r   = f2[30];
            in_st  = |f2[29:0];
            in_sig = {f2[55:32], 29'b0};
        end

        in_grs = in_g | in_r | in_st;

        in_inc = 1'b0;
        case (RM)
            RM_RZ:   in_inc = 1'b0;
            RM_RNE:  in_inc = in_g & (in_r | in_st | in_lsb);
            RM_RUP:  in_inc = ~s & in_grs;
            RM_RDN:  in_inc = s & in_grs;
            default: in_inc = 1'b0;
        endcase
    end

    // Stage 1 next state: load on accept, otherwise hold
    always_comb begin
        s1_s_d   = s1_s_q;
        s1_e_d   = s1_e_q;
        s1_sig_d = s1_sig_q;
        s1_inc_d = s1_inc_q;
        s1_inx_d = s1_inx_q;
        s1_rm_d  = s1_rm_q;
        s1_db_d  = s1_db_q;
        if (in_fire) begin
            s1_s_d   = s;
            s1_e_d   = e2;
            s1_sig_d = in_sig;
            s1_inc_d = in_inc;
            s1_inx_d = in_grs;
            s1_rm_d  = RM;
            s1_db_d  = db;
        end
    end

    // Stage 2 datapath: add inc at the format lsb, renormalize on carry
    always_comb begin
        if (s1_db_q)
            sum = {1'b0, s1_sig_q} + 54'(s1_inc_q);
        else
            sum = {1'b0, s1_sig_q} + (54'(s1_inc_q) << SG_LSB);

        // Carry out of the integer bit only happens from all-ones, so the
        // rounded significand is exactly 1.0 and the exponent steps up.
        // A denormal rounding into 1.0 sets bit 52 without a carry and
        // keeps its exponent.
        if (sum[53]) begin
            sig_r = {1'b1, 52'b0};
            exp_r = s1_e_q + EXP_W'(1);
        end else begin
            sig_r = sum[52:0];
            exp_r = s1_e_q;
        end

        // Bits below the single lsb never carry information
        if (!s1_db_q)
            sig_r[SG_LSB-1:0] = '0;

        ovf_r = s1_db_q ? (exp_r >= OVF_DB) : (exp_r >= OVF_SG);
    end

    // Stage 2 next state: load when stage 1 advances, otherwise hold stable
    always_comb begin
        s_out_d  = s_out_q;
        e3_d     = e3_q;
        f3_d     = f3_q;
        rm_out_d = rm_out_q;
        db_out_d = db_out_q;
        ovf_d    = ovf_q;
        inx_d    = inx_q;
        if (s1_adv) begin
            s_out_d  = s1_s_q;
            e3_d     = s1_db_q ? exp_r[10:0] : {3'b000, exp_r[7:0]};
            f3_d     = {sig_r[51:0], sig_r[52]};
            rm_out_d = s1_rm_q;
            db_out_d = s1_db_q;
            ovf_d    = ovf_r;
            inx_d    = s1_inx_q | ovf_r;
        end
    end

    // Valid-bit register; reset drops any in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe_q <= '0;
        else
            vld_pipe_q <= vld_pipe_d;
    end

    // Stage 1 data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_s_q   <= 1'b0;
            s1_e_q   <= '0;
            s1_sig_q <= '0;
            s1_inc_q <= 1'b0;
            s1_inx_q <= 1'b0;
            s1_rm_q  <= 2'b00;
            s1_db_q  <= 1'b0;
        end else begin
            s1_s_q   <= s1_s_d;
            s1_e_q   <= s1_e_d;
            s1_sig_q <= s1_sig_d;
            s1_inc_q <= s1_inc_d;
            s1_inx_q <= s1_inx_d;
            s1_rm_q  <= s1_rm_d;
            s1_db_q  <= s1_db_d;
        end
    end

    // Stage 2 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_out_q  <= 1'b0;
            e3_q     <= '0;
            f3_q     <= '0;
            rm_out_q <= 2'b00;
            db_out_q <= 1'b0;
            ovf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            s_out_q  <= s_out_d;
            e3_q     <= e3_d;
            f3_q     <= f3_d;
            rm_out_q <= rm_out_d;
            db_out_q <= db_out_d;
            ovf_q    <= ovf_d;
            inx_q    <= inx_d;
        end
    end

    // Output drive
    always_comb begin
        out_valid = vld_pipe_q[2];
        s_out     = s_out_q;
        e3        = e3_q;
        f3        = f3_q;
        RM_out    = rm_out_q;
        db_out    = db_out_q;
        OVF       = ovf_q;
        INX       = inx_q;
    end

endmodule

// File: tb/tb_sigrnd_pipe.sv
// Directed bench for sigrnd_pipe: hand-computed vectors per feature,
// plus streaming, backpressure and mid-stream reset scenarios.
module tb_sigrnd_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic [12:0] e2;
    logic [55:0] f2;
    logic [1:0]  RM;
    logic        db;
    logic        out_valid;
    logic        out_ready;
    logic        s_out;
    logic [10:0] e3;
    logic [52:0] f3;
    logic [1:0]  RM_out;
    logic        db_out;
    logic        OVF;
    logic        INX;

    int errors = 0;
    int checks = 0;

    sigrnd_pipe #(.EXP_W(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .e2        (e2),
        .f2        (f2),
        .RM        (RM),
        .db        (db),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .e3        (e3),
        .f3        (f3),
        .RM_out    (RM_out),
        .db_out    (db_out),
        .OVF       (OVF),
        .INX       (INX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat for one cycle, then wait one more edge so it sits in
    // the output stage (two edges after it was presented).
    task automatic issue(input logic si, input logic [12:0] ei, input logic [55:0] fi,
                         input logic [1:0] rmi, input logic dbi);
        s = si; e2 = ei; f2 = fi; RM = rmi; db = dbi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e2 = 13'h1ABC; f2 = 56'hDEAD_BEEF_0000_00; RM = 2'b01; s = ~si;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s = 0; e2 = 0; f2 = 0; RM = 0; db = 0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || e3 !== 11'h0 || f3 !== 53'h0 || OVF !== 1'b0 ||
            INX !== 1'b0 || s_out !== 1'b0 || RM_out !== 2'b00 || db_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b e3=%h f3=%h ovf=%b inx=%b s=%b rm=%b db=%b want all 0",
                     out_valid, e3, f3, OVF, INX, s_out, RM_out, db_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Double-precision round-to-nearest-even cases
    task automatic test_double_rne();
        logic [55:0] vf  [3];
        logic [52:0] wf3 [3];
        logic        winx[3];
        vf[0] = 56'h80_0000_0000_0004; wf3[0] = 53'h1; winx[0] = 1'b1; // tie, even lsb: stays
        vf[1] = 56'h80_0000_0000_000C; wf3[1] = 53'h5; winx[1] = 1'b1; // tie, odd lsb: frac 1->2
        vf[2] = 56'h80_0000_0000_0008; wf3[2] = 53'h3; winx[2] = 1'b0; // exact
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 13'd1023, vf[i], 2'b01, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || e3 !== 11'd1023 || f3 !== wf3[i] || OVF !== 1'b0 ||
                INX !== winx[i] || db_out !== 1'b1 || RM_out !== 2'b01) begin
                errors++;
                $display("FAIL dbl_rne[%0d]: ov=%b e3=%0d f3=%h ovf=%b inx=%b db=%b rm=%b want ov=1 e3=1023 f3=%h ovf=0 inx=%b db=1 rm=01",
                         i, out_valid, e3, f3, OVF, INX, db_out, RM_out, wf3[i], winx[i]);
            end
        end
    endtask

    // Carry out of the integer bit and exponent overflow boundaries
    task automatic test_carry_ovf();
        issue(1'b0, 13'd2046, 56'hFF_FFFF_FFFF_FFFC, 2'b01, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || e3 !== 11'h7FF || f3 !== 53'h1 || OVF !== 1'b1 || INX !== 1'b1) begin
            errors++;
            $display("FAIL dbl_carry_ovf: ov=%b e3=%h f3=%h ovf=%b inx=%b want ov=1 e3=7ff f3=1 ovf=1 inx=1",
                     out_valid, e3, f3, OVF, INX);
        end
        issue(1'b0, 13'd2046, 56'hFF_FFFF_FFFF_FFFC, 2'b00, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || e3 !== 11'h7FE || f3 !== 53'h1F_FFFF_FFFF_FFFF || OVF !== 1'b0 || INX !== 1'b1) begin
            errors++;
            $display("FAIL dbl_rz_no_carry: ov=%b e3=%h f3=%h ovf=%b inx=%b want ov=1 e3=7fe f3=1fffffffffffff ovf=0 inx=1",
                     out_valid, e3, f3, OVF, INX);
        end
        // Single: 254 with all-ones significand and G=1 carries into 255
        issue(1'b0, 13'd254, 56'hFF_FFFF_8000_0000, 2'b01, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || e3 !== 11'h0FF || f3 !== 53'h1 || OVF !== 1'b1 || INX !== 1'b1) begin
            errors++;
            $display("FAIL sgl_carry_ovf: ov=%b e3=%h f3=%h ovf=%b inx=%b want ov=1 e3=0ff f3=1 ovf=1 inx=1",
                     out_valid, e3, f3, OVF, INX);
        end
    endtask

    // Single-precision directed rounding driven by sticky only
    task automatic test_single_directed();
        issue(1'b1, 13'd127, 56'h80_0001_0000_0001, 2'b11, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || e3 !== 11'd127 || f3 !== 53'h8000_0001 || OVF !== 1'b0 ||
            INX !== 1'b1 || s_out !== 1'b1 || db_out !== 1'b0 || RM_out !== 2'b11) begin
            errors++;
            $display("FAIL sgl_rdn: ov=%b e3=%0d f3=%h ovf=%b inx=%b s=%b db=%b rm=%b want e3=127 f3=80000001 ovf=0 inx=1 s=1 db=0 rm=11",
                     out_valid, e3, f3, OVF, INX, s_out, db_out, RM_out);
        end
        issue(1'b1, 13'd127, 56'h80_0001_0000_0001, 2'b10, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || e3 !== 11'd127 || f3 !== 53'h4000_0001 || OVF !== 1'b0 || INX !== 1'b1) begin
            errors++;
            $display("FAIL sgl_rup_neg: ov=%b e3=%0d f3=%h ovf=%b inx=%b want e3=127 f3=40000001 ovf=0 inx=1",
                     out_valid, e3, f3, OVF, INX);
        end
    endtask

    // Denormal rounding up into 1.0 keeps exponent 1
    task automatic test_denormal();
        issue(1'b0, 13'd1, 56'h7F_FFFF_FFFF_FFF9, 2'b10, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || e3 !== 11'd1 || f3 !== 53'h1 || OVF !== 1'b0 || INX !== 1'b1) begin
            errors++;
            $display("FAIL denorm_roundup: ov=%b e3=%0d f3=%h ovf=%b inx=%b want e3=1 f3=1 ovf=0 inx=1",
                     out_valid, e3, f3, OVF, INX);
        end
    endtask

    // Four beats on consecutive cycles with no stall: one result per cycle
    task automatic test_back_to_back();
        logic [51:0] fr;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                fr = 52'(i + 7);
                s = 1'b0; e2 = 13'(200 + i); f2 = {1'b1, fr, 3'b000}; RM = 2'b00; db = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
                end
            end
            if (i >= 2) begin
                fr = 52'(i - 2 + 7);
                checks++;
                if (out_valid !== 1'b1 || e3 !== 11'(200 + i - 2) || f3 !== {fr, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: ov=%b e3=%0d f3=%h want ov=1 e3=%0d f3=%h",
                             i - 2, out_valid, e3, f3, 200 + i - 2, {fr, 1'b1});
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    // Six beats streamed with the consumer stalled for iterations 3..6
    task automatic test_backpressure();
        int          tx, rx;
        logic        fire_in, fire_out, prev_stall, saw_full;
        logic [66:0] snap;
        logic [51:0] fr;
        tx = 0; rx = 0; prev_stall = 1'b0; saw_full = 1'b0; snap = '0;
        for (int it = 0; it < 30 && rx < 6; it++) begin
            out_ready = !(it >= 3 && it <= 6);
            if (tx < 6) begin
                fr = 52'(tx + 1);
                s = 1'b0; e2 = 13'(100 + tx); f2 = {1'b1, fr, 3'b000}; RM = 2'b00; db = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            fire_in  = in_valid & in_ready;
            fire_out = out_valid & out_ready;
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {e3, f3, OVF, INX, s_out} !== snap) begin
                    errors++;
                    $display("FAIL bp_stable[%0d]: ov=%b e3=%0d f3=%h want held e3=%0d f3=%h",
                             it, out_valid, e3, f3, snap[66:56], snap[55:3]);
                end
            end
            if (fire_out) begin
                fr = 52'(rx + 1);
                checks++;
                if (e3 !== 11'(100 + rx) || f3 !== {fr, 1'b1} || INX !== 1'b0 || OVF !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: e3=%0d f3=%h inx=%b ovf=%b want e3=%0d f3=%h inx=0 ovf=0",
                             rx, e3, f3, INX, OVF, 100 + rx, {fr, 1'b1});
                end
            end
            prev_stall = out_valid & ~out_ready;
            snap = {e3, f3, OVF, INX, s_out};
            @(posedge clk); #1;
            if (fire_in)  tx++;
            if (fire_out) rx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 6 || tx != 6) begin
            errors++;
            $display("FAIL bp_count: sent=%0d received=%0d want 6/6", tx, rx);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_drop: never deasserted, want 0 while full");
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid=%b want 0 after last beat", out_valid);
        end
        @(posedge clk); #1;
    endtask

    // Reset with both stages occupied drops everything
    task automatic test_reset_midstream();
        out_ready = 1'b0;
        s = 1'b0; e2 = 13'd300; f2 = 56'h80_0000_0000_0008; RM = 2'b00; db = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        e2 = 13'd301;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full: ov=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || e3 !== 11'h0 || f3 !== 53'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_clear: ov=%b e3=%h f3=%h in_ready=%b want 0/0/0/1",
                     out_valid, e3, f3, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_after[%0d]: ov=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_double_rne();
        test_carry_ovf();
        test_single_directed();
        test_denormal();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sigrnd_pipe.md
Name: sigrnd_pipe

Overview:
- Two-stage pipelined significand rounder; sits directly upstream of the exponent-rounding/packing stage.
- Takes a normalized, sticky-compressed significand plus biased exponent, applies the rounding mode, post-normalizes on rounding carry and flags overflow/inexact.
- Outputs exactly the e3/f3/OVF form the packing stage consumes.
- Valid/ready handshake on both sides, so the FPU back end can stall.

Parameters:
EXP_W, 13, input exponent width (unsigned biased, headroom above 2047)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- s  in  1  sign
- e2  in  EXP_W  biased exponent; single uses the 127 bias, double the 1023 bias; range 1..4094
- f2  in  56  significand: [55] integer bit, [54:3] 52-bit fraction, [2] guard, [1] round, [0] sticky (double)
- RM  in  2  rounding mode: 00 RZ, 01 RNE, 10 toward +inf, 11 toward -inf
- db  in  1  1 = double, 0 = single
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- s_out  out  1  registered sign
- e3  out  11  rounded biased exponent; single occupies [7:0] with [10:8] = 0
- f3  out  53  {fraction[51:0], hidden}; single fraction in [52:30], [29:1] = 0
- RM_out, db_out  out  2, 1  forwarded for the packing stage
- OVF  out  1  rounded exponent ≥ 2047 (db) / 255 (single)
- INX  out  1  any discarded bit nonzero, or OVF

Behaviour:
- Reset (async, rst_n = 0): both stage valid bits cleared; out_valid = 0. s_out, e3, f3, RM_out, db_out, OVF and INX all = 0. Reset mid-operation drops in-flight beats; no partial output. in_ready = 1 after release.
- Pipeline:
  - Stage 1 registers the input beat. It extracts lsb/guard/round/sticky per format:
    - double: lsb = f2[3], G = f2[2], R = f2[1], S = f2[0]
    - single: lsb = f2[32], G = f2[31], R = f2[30], S = |f2[29:0]
  - Stage 1 computes inc:
    - RZ: 0
    - RNE: G & (R | S | lsb)
    - +inf: ~s & (G|R|S)
    - -inf: s & (G|R|S)
  - Stage 1 computes inx = G|R|S.
  - Stage 2 adds inc at the lsb position of the 53-bit (double) or 24-bit (single) significand.
    - Carry out of the integer bit: significand becomes 1.000…, exponent + 1.
    - Fraction bits below the format lsb are forced to 0.
  - Stage 2 sets OVF when the post-rounding exponent ≥ 2047 (db) / 255 (single).
    - e3 = the low 11 (db) / 8 (single) bits of that exponent; the packing stage overrides it on OVF.
  - INX = inx | OVF.
  - hidden = post-rounding integer bit. A denormal (integer bit 0) that rounds up into 1.0 gets hidden = 1 with the exponent unchanged at 1.
- Latency: 2 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+2, when not stalled.
- Handshake:
  - A stage advances when its successor is empty or advancing.
  - in_ready = ~s1_valid | s2_advance_path (combinational from out_ready; no bubble when streaming).
  - Throughput 1 beat/cycle.
  - While out_valid & ~out_ready, all output fields stay stable.
  - Input accepted only when in_valid & in_ready. Data on ports is ignored when in_valid = 0.
- Boundaries:
  - Full pipeline with out_ready = 0: in_ready = 0, no beat lost or duplicated.
  - Simultaneous output drain and input accept in the same cycle: both occur, ordering preserved.
  - e2 = 2046 (db) with round-up carry → OVF = 1, INX = 1.
  - Exponent arithmetic is EXP_W wide; no wrap within the legal input range.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with 2 beats in flight → out_valid = 0 immediately, no output after release, in_ready = 1.
- Double RNE tie-to-even: db = 1, RM = 01, e2 = 1023, f2 = {1, 52'b0, G = 1, R = 0, S = 0} → 2 cycles later e3 = 1023, f3 = 53'h1, OVF = 0, INX = 1. Same beat with f2[3] = 1 → fraction lsb carries: f3 = {51'b0, 1'b1, 1'b1} becomes fraction = 2, INX = 1.
- Carry/overflow: db = 1, RM = 01, e2 = 2046, f2[55:3] all ones, G = 1 → f3 = 53'h1, e3 = 2047 low bits, OVF = 1, INX = 1. Same with RM = 00 → no increment, OVF = 0, f3 = {52'hF_FFFF_FFFF_FFFF, 1}.
- Single directed rounding: db = 0, s = 1, RM = 11, e2 = 127, f2[55:32] = 24'h800001, f2[0] = 1 only → fraction lsb incremented: f3[52:30] = 23'h000002, e3 = 127, INX = 1. RM = 10 on the same beat → no increment.
- Backpressure: stream 6 beats back-to-back, hold out_ready = 0 for cycles 3–6 → in_ready drops once both stages are full; outputs stay stable; all 6 beats emerge in order, no duplicates.
- Denormal round-up: db = 1, RM = 10, s = 0, e2 = 1, f2[55:3] = {0, 52 ones}, S = 1 → hidden = 1, fraction = 0, e3 = 1, OVF = 0.
